// File: rtl/genetic_pkg.sv
// Shared types and constants for the serially loaded evolvable LUT grid.
//   tt_t    : 16-entry truth table of one 4-input cell
//   IDX_*   : bit position of each neighbour inside the 4-bit LUT index
//   state_t : evaluation FSM states
package genetic_pkg;

    typedef logic [15:0] tt_t;

    localparam int IDX_LEFT  = 0;
    localparam int IDX_DOWN  = 1;
    localparam int IDX_RIGHT = 2;
    localparam int IDX_UP    = 3;

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

endpackage

// File: rtl/genetic_grid_serial_if.sv
// Handshake bundle of the grid: genotype stream (cfg_*), evaluation request
// (eval_*, inp, settle_cycles) and result channel (out_*).
//   master : genotype source / evaluator side
//   slave  : the grid
interface genetic_grid_serial_if #(
    parameter int ROWS     = 4,
    parameter int N_OUT    = 1,
    parameter int SETTLE_W = 4
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [15:0]         cfg_data;
    logic                cfg_done;
    logic                eval_valid;
    logic                eval_ready;
    logic [ROWS-1:0]     inp;
    logic [SETTLE_W-1:0] settle_cycles;
    logic                out_valid;
    logic                out_ready;
    logic [N_OUT-1:0]    out;
    logic                out_stable;

    modport master (
        output cfg_valid, cfg_data, eval_valid, inp, settle_cycles, out_ready,
        input  cfg_ready, cfg_done, eval_ready, out_valid, out, out_stable
    );

    modport slave (
        input  cfg_valid, cfg_data, eval_valid, inp, settle_cycles, out_ready,
        output cfg_ready, cfg_done, eval_ready, out_valid, out, out_stable
    );
endinterface

// File: rtl/ge_cell.sv
// Registered 4-input LUT cell.
//   tt       : active truth table
//   up/right/down/left : registered neighbour values (boundary tied off by parent)
//   clr      : synchronous clear to 0 (start of an evaluation)
//   upd      : take one grid step
//   q        : cell register
//   changed  : next value differs from q (meaningful while upd)
module ge_cell
    import genetic_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  tt_t  tt,
    input  logic up,
    input  logic right,
    input  logic down,
    input  logic left,
    input  logic clr,
    input  logic upd,
    output logic q,
    output logic changed
);
    logic [3:0] idx;
    logic       nxt;

    always_comb begin
        idx            = '0;
        idx[IDX_UP]    = up;
        idx[IDX_RIGHT] = right;
        idx[IDX_DOWN]  = down;
        idx[IDX_LEFT]  = left;
    end

    assign nxt     = tt[idx];
    assign changed = nxt ^ q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= 1'b0;
        else if (clr) q <= 1'b0;
        else if (upd) q <= nxt;
    end
endmodule

// File: rtl/genetic_grid_serial.sv
// ROWS x COLS grid of registered LUT cells with serial genotype load.
//   clk, rst_n : clock, async active-low reset
//   bus        : cfg stream into a shadow bank, eval request, result channel
// Beats 0..NCELL-1 carry truth tables (row-major), then N_OUT selector beats.
// The shadow bank is committed only while the eval FSM is IDLE, so a
// running evaluation always sees one consistent genotype.
module genetic_grid_serial
    import genetic_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int N_OUT    = 1,
    parameter int SETTLE_W = 4
) (
    input logic clk,
    input logic rst_n,
    genetic_grid_serial_if.slave bus
);
    localparam int NCELL     = ROWS * COLS;
    localparam int SEL_W     = $clog2(NCELL + 1);
    localparam int CFG_BEATS = NCELL + N_OUT;
    localparam int CNT_W     = $clog2(CFG_BEATS);

    tt_t              shadow_tt  [NCELL];
    tt_t              act_tt     [NCELL];
    logic [SEL_W-1:0] shadow_sel [N_OUT];
    logic [SEL_W-1:0] act_sel    [N_OUT];

    logic [CNT_W-1:0]    cfg_cnt;
    logic                pending, cfg_done_r;
    state_t              state, state_nxt;
    logic [SETTLE_W-1:0] cnt;
    logic [ROWS-1:0]     inp_l;
    logic [NCELL-1:0]    q, chg;
    logic [N_OUT-1:0]    out_mux, out_hold;
    logic                stable_r;
    logic                cfg_acc, eval_acc, commit, last_beat, upd;

    assign commit    = pending && (state == IDLE);
    assign cfg_acc   = bus.cfg_valid && !pending;
    assign eval_acc  = bus.eval_valid && bus.eval_ready;
    assign last_beat = cfg_acc && (cfg_cnt == CNT_W'(CFG_BEATS - 1));
    assign upd       = (state == SETTLE);

    assign bus.cfg_ready  = !pending;
    // A pending commit blocks new evaluations so it lands before the next run.
    assign bus.eval_ready = (state == IDLE) && !pending;
    assign bus.cfg_done   = cfg_done_r;
    assign bus.out_valid  = (state == DONE);
    assign bus.out_stable = stable_r;
    // Live mux in DONE; afterwards the captured copy keeps the result steady
    // even if a commit changes the selectors or a new run clears the cells.
    assign bus.out        = (state == DONE) ? out_mux : out_hold;

    // Genotype load / commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_cnt    <= '0;
            pending    <= 1'b0;
            cfg_done_r <= 1'b0;
            for (int k = 0; k < NCELL; k++) begin
                shadow_tt[k] <= '0;
                act_tt[k]    <= '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                shadow_sel[j] <= '0;
                act_sel[j]    <= '0;
            end
        end else begin
            cfg_done_r <= commit;
            if (cfg_acc) begin
                for (int k = 0; k < NCELL; k++)
                    if (cfg_cnt == CNT_W'(k)) shadow_tt[k] <= bus.cfg_data;
                for (int j = 0; j < N_OUT; j++)
                    if (cfg_cnt == CNT_W'(NCELL + j)) shadow_sel[j] <= bus.cfg_data[SEL_W-1:0];
                cfg_cnt <= last_beat ? '0 : cfg_cnt + CNT_W'(1);
            end
            if (last_beat)   pending <= 1'b1;
            else if (commit) pending <= 1'b0;
            if (commit) begin
                act_tt  <= shadow_tt;
                act_sel <= shadow_sel;
            end
        end
    end

    // Eval FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (eval_acc) state_nxt = SETTLE;
            SETTLE:  if (cnt == SETTLE_W'(1)) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            inp_l    <= '0;
            out_hold <= '0;
            stable_r <= 1'b0;
        end else begin
            if (eval_acc) begin
                inp_l <= bus.inp;
                cnt   <= (bus.settle_cycles == '0) ? SETTLE_W'(1) : bus.settle_cycles;
            end else if (state == SETTLE) begin
                cnt <= cnt - SETTLE_W'(1);
                if (cnt == SETTLE_W'(1)) stable_r <= !(|chg);
            end
            if (state == DONE) out_hold <= out_mux;
        end
    end

    // Output selectors; an out-of-range selector matches no cell and reads 0.
    always_comb begin
        out_mux = '0;
        for (int j = 0; j < N_OUT; j++)
            for (int k = 0; k < NCELL; k++)
                if (act_sel[j] == SEL_W'(k)) out_mux[j] = q[k];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int K = r * COLS + c;
            logic up, rt, dn, lf;
            if (r == 0)        begin : g_up assign up = 1'b0;        end
            else               begin : g_up assign up = q[K-COLS];   end
            if (c == COLS - 1) begin : g_rt assign rt = 1'b0;        end
            else               begin : g_rt assign rt = q[K+1];      end
            if (r == ROWS - 1) begin : g_dn assign dn = 1'b0;        end
            else               begin : g_dn assign dn = q[K+COLS];   end
            if (c == 0)        begin : g_lf assign lf = inp_l[r];    end
            else               begin : g_lf assign lf = q[K-1];      end

            ge_cell u_cell (
                .clk     (clk),
                .rst_n   (rst_n),
                .tt      (act_tt[K]),
                .up      (up),
                .right   (rt),
                .down    (dn),
                .left    (lf),
                .clr     (eval_acc),
                .upd     (upd),
                .q       (q[K]),
                .changed (chg[K])
            );
        end
    end
endmodule

// File: tb/tb_genetic_grid_serial.sv
module tb_genetic_grid_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    genetic_grid_serial_if #(.ROWS(4), .N_OUT(1), .SETTLE_W(4)) ia ();
    genetic_grid_serial_if #(.ROWS(3), .N_OUT(1), .SETTLE_W(4)) ib ();

    genetic_grid_serial #(.ROWS(4), .COLS(4), .N_OUT(1), .SETTLE_W(4))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    genetic_grid_serial #(.ROWS(3), .COLS(5), .N_OUT(1), .SETTLE_W(4))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    typedef struct packed { logic o; logic st; } exp_t;
    exp_t qa[$], qb[$];
    int n_chk = 0, n_fail = 0;

    logic [15:0] a_act_tt[32], a_sh_tt[32], b_act_tt[32], b_sh_tt[32];
    int a_act_sel, a_sh_sel, b_act_sel, b_sh_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: iterate the grid rules directly on plain arrays.
    function automatic logic [1:0] model(input logic [15:0] tt[32], input int sel,
                                         input logic [7:0] inp, input int s,
                                         input int R, input int C);
        logic cur[32], nx[32];
        logic chg, up, rt, dn, lf;
        int eff, k;
        for (int i = 0; i < 32; i++) begin cur[i] = 1'b0; nx[i] = 1'b0; end
        chg = 1'b0;
        eff = (s == 0) ? 1 : s;
        for (int t = 0; t < eff; t++) begin
            chg = 1'b0;
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) begin
                    k  = r * C + c;
                    up = (r > 0)     ? cur[k-C] : 1'b0;
                    rt = (c < C - 1) ? cur[k+1] : 1'b0;
                    dn = (r < R - 1) ? cur[k+C] : 1'b0;
                    lf = (c > 0)     ? cur[k-1] : inp[r];
                    nx[k] = tt[k][{up, rt, dn, lf}];
                    if (nx[k] != cur[k]) chg = 1'b1;
                end
            cur = nx;
        end
        return {(sel < R * C) ? cur[sel] : 1'b0, !chg};
    endfunction

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && ia.out_valid && ia.out_ready) begin
            if (qa.size() == 0) check("a unexpected result", 1, 0);
            else begin
                e = qa.pop_front();
                check("a out", 32'(ia.out), 32'(e.o));
                check("a out_stable", 32'(ia.out_stable), 32'(e.st));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && ib.out_valid && ib.out_ready) begin
            if (qb.size() == 0) check("b unexpected result", 1, 0);
            else begin
                e = qb.pop_front();
                check("b out", 32'(ib.out), 32'(e.o));
                check("b out_stable", 32'(ib.out_stable), 32'(e.st));
            end
        end
    end

    // ---------------- DUT A drivers ----------------
    task automatic send_a(input logic [15:0] d, input bit gap);
        int n = 0;
        if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        ia.cfg_valid = 1'b1; ia.cfg_data = d;
        @(negedge clk);
        while (!ia.cfg_ready && n < 100) begin n++; @(negedge clk); end
        if (!ia.cfg_ready) check("a cfg_ready timeout", 0, 1);
        @(posedge clk); #1;
        ia.cfg_valid = 1'b0;
    endtask

    task automatic load_a(input bit gap);
        for (int k = 0; k < 16; k++) send_a(a_sh_tt[k], gap);
        send_a(16'(a_sh_sel), gap);
    endtask

    task automatic wait_done_a();
        int n = 0;
        do begin @(negedge clk); n++; end while (!ia.cfg_done && n < 50);
        check("a cfg_done", 32'(ia.cfg_done), 1);
        a_act_tt = a_sh_tt; a_act_sel = a_sh_sel;
        @(posedge clk); #1;
    endtask

    task automatic eval_a(input logic [3:0] inp, input logic [3:0] s, input bit lat);
        logic [1:0] e;
        int n = 0, eff;
        bit early = 0;
        ia.eval_valid = 1'b1; ia.inp = inp; ia.settle_cycles = s;
        @(negedge clk);
        while (!ia.eval_ready && n < 100) begin n++; @(negedge clk); end
        if (!ia.eval_ready) check("a eval_ready timeout", 0, 1);
        e = model(a_act_tt, a_act_sel, {4'b0, inp}, int'(s), 4, 4);
        qa.push_back(exp_t'(e));
        @(posedge clk); #1;
        ia.eval_valid = 1'b0;
        if (lat) begin
            eff = (s == 0) ? 1 : int'(s);
            for (int i = 0; i < eff; i++) begin
                @(negedge clk);
                if (ia.out_valid) early = 1;
            end
            @(negedge clk);
            check("a out_valid early", 32'(early), 0);
            check("a latency", 32'(ia.out_valid), 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain_a();
        int n = 0;
        while (qa.size() != 0 && n < 100) begin @(posedge clk); n++; end
        #1;
        if (qa.size() != 0) check("a result timeout", 32'(qa.size()), 0);
        qa.delete();
    endtask

    task automatic rand_cfg_a();
        for (int k = 0; k < 16; k++) a_sh_tt[k] = 16'($urandom);
        a_sh_sel = $urandom_range(0, 17);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, " out_valid"}, 32'(ia.out_valid), 0);
        check({tag, " out"}, 32'(ia.out), 0);
        check({tag, " out_stable"}, 32'(ia.out_stable), 0);
        check({tag, " cfg_done"}, 32'(ia.cfg_done), 0);
        check({tag, " cfg_ready"}, 32'(ia.cfg_ready), 1);
        check({tag, " eval_ready"}, 32'(ia.eval_ready), 1);
    endtask

    // ---------------- DUT B drivers ----------------
    task automatic send_b(input logic [15:0] d);
        int n = 0;
        ib.cfg_valid = 1'b1; ib.cfg_data = d;
        @(negedge clk);
        while (!ib.cfg_ready && n < 100) begin n++; @(negedge clk); end
        if (!ib.cfg_ready) check("b cfg_ready timeout", 0, 1);
        @(posedge clk); #1;
        ib.cfg_valid = 1'b0;
    endtask

    task automatic load_b();
        int n = 0;
        for (int k = 0; k < 15; k++) send_b(b_sh_tt[k]);
        send_b(16'(b_sh_sel));
        do begin @(negedge clk); n++; end while (!ib.cfg_done && n < 50);
        check("b cfg_done", 32'(ib.cfg_done), 1);
        b_act_tt = b_sh_tt; b_act_sel = b_sh_sel;
        @(posedge clk); #1;
    endtask

    task automatic eval_b(input logic [2:0] inp, input logic [3:0] s);
        int n = 0;
        ib.eval_valid = 1'b1; ib.inp = inp; ib.settle_cycles = s;
        @(negedge clk);
        while (!ib.eval_ready && n < 100) begin n++; @(negedge clk); end
        if (!ib.eval_ready) check("b eval_ready timeout", 0, 1);
        qb.push_back(exp_t'(model(b_act_tt, b_act_sel, {5'b0, inp}, int'(s), 3, 5)));
        @(posedge clk); #1;
        ib.eval_valid = 1'b0;
        n = 0;
        while (qb.size() != 0 && n < 100) begin @(posedge clk); n++; end
        #1;
        if (qb.size() != 0) check("b result timeout", 32'(qb.size()), 0);
        qb.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        exp_t hold_e;
        int n;
        ia.cfg_valid = 0; ia.cfg_data = 0; ia.eval_valid = 0; ia.inp = 0;
        ia.settle_cycles = 0; ia.out_ready = 1;
        ib.cfg_valid = 0; ib.cfg_data = 0; ib.eval_valid = 0; ib.inp = 0;
        ib.settle_cycles = 0; ib.out_ready = 1;
        for (int k = 0; k < 32; k++) begin
            a_act_tt[k] = 0; a_sh_tt[k] = 0; b_act_tt[k] = 0; b_sh_tt[k] = 0;
        end
        a_act_sel = 0; a_sh_sel = 0; b_act_sel = 0; b_sh_sel = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_a("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // all-zero genotype after reset: output 0, converged
        eval_a(4'($urandom), 4'd3, 1'b1); drain_a();

        // shift chain along row 0
        for (int k = 0; k < 16; k++) a_sh_tt[k] = 16'hAAAA;
        a_sh_sel = 3;
        load_a(1'b0); wait_done_a();
        eval_a(4'b0001, 4'd4, 1'b1); drain_a();
        eval_a(4'b0001, 4'd5, 1'b1); drain_a();
        eval_a(4'b0001, 4'd3, 1'b1); drain_a();

        // two-cell oscillator
        for (int k = 0; k < 16; k++) a_sh_tt[k] = 16'h0000;
        a_sh_tt[0] = 16'hF0F0; a_sh_tt[1] = 16'h5555; a_sh_sel = 0;
        load_a(1'b1); wait_done_a();
        eval_a(4'($urandom), 4'd2, 1'b1); drain_a();
        eval_a(4'($urandom), 4'd4, 1'b1); drain_a();

        // result held under back-pressure; settle 0 acts as 1
        ia.out_ready = 1'b0;
        eval_a(4'b0001, 4'd0, 1'b1);
        hold_e = qa[0];
        repeat (10) begin
            @(negedge clk);
            check("hold out_valid", 32'(ia.out_valid), 1);
            check("hold out", 32'(ia.out), 32'(hold_e.o));
            check("hold out_stable", 32'(ia.out_stable), 32'(hold_e.st));
        end
        @(posedge clk); #1 ia.out_ready = 1'b1;
        drain_a();
        @(negedge clk);
        check("idle out kept", 32'(ia.out), 32'(hold_e.o));
        check("idle out_stable kept", 32'(ia.out_stable), 32'(hold_e.st));
        @(posedge clk); #1;

        // config B streamed during a long evaluation on config A
        rand_cfg_a();
        ia.out_ready = 1'b0;
        eval_a(4'($urandom), 4'd15, 1'b0);
        load_a(1'b0);
        @(negedge clk);
        check("cfg_ready after last beat", 32'(ia.cfg_ready), 0);
        check("no early commit", 32'(ia.cfg_done), 0);
        n = 0;
        while (!ia.out_valid && n < 40) begin @(negedge clk); n++; end
        check("long eval done", 32'(ia.out_valid), 1);
        @(posedge clk); #1 ia.out_ready = 1'b1;
        @(posedge clk); #1;
        check("result used old cfg", 32'(qa.size()), 0);
        @(negedge clk);
        check("commit cycle cfg_done", 32'(ia.cfg_done), 0);
        check("commit cycle eval_ready", 32'(ia.eval_ready), 0);
        @(negedge clk);
        check("cfg_done pulse", 32'(ia.cfg_done), 1);
        @(negedge clk);
        check("cfg_done one cycle", 32'(ia.cfg_done), 0);
        a_act_tt = a_sh_tt; a_act_sel = a_sh_sel;
        @(posedge clk); #1;
        eval_a(4'($urandom), 4'($urandom), 1'b1); drain_a();

        // randomized genotypes / inputs / settle counts
        repeat (6) begin
            rand_cfg_a();
            load_a(1'b1); wait_done_a();
            repeat (2) begin eval_a(4'($urandom), 4'($urandom), 1'b1); drain_a(); end
        end

        // reset during a partial load
        rand_cfg_a();
        for (int k = 0; k < 7; k++) send_a(a_sh_tt[k], 1'b0);
        rst_n = 1'b0;
        for (int k = 0; k < 32; k++) a_act_tt[k] = 0;
        a_act_sel = 0;
        @(negedge clk);
        check_reset_a("midload reset");
        @(posedge clk); #1 rst_n = 1'b1;
        rand_cfg_a();
        load_a(1'b0); wait_done_a();
        eval_a(4'($urandom), 4'($urandom), 1'b1); drain_a();

        // reset during SETTLE: run is dropped
        eval_a(4'($urandom), 4'd10, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        qa.delete();
        for (int k = 0; k < 32; k++) a_act_tt[k] = 0;
        a_act_sel = 0;
        @(negedge clk);
        check("midsettle out_valid", 32'(ia.out_valid), 0);
        check("midsettle eval_ready", 32'(ia.eval_ready), 1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        eval_a(4'($urandom), 4'd2, 1'b1); drain_a();

        // 3x5 grid: out-of-range selector and the last cell
        for (int k = 0; k < 15; k++) b_sh_tt[k] = 16'($urandom);
        b_sh_sel = 15;
        load_b();
        for (int i = 0; i < 8; i++) eval_b(3'(i), 4'($urandom));
        b_sh_tt[14] = 16'hFFFF; b_sh_sel = 14;
        load_b();
        eval_b(3'($urandom), 4'd1);
        eval_b(3'($urandom), 4'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
